// File: rtl/deser_param.sv
// rtl/deser_param.sv - parametrised serial-to-parallel deserializer
//
// Purpose:
//   Collects a qualified single-bit stream into DATA_W-bit words in either
//   bit order. It can optionally emit a partial word on a flush request.
//   The emitted word and its valid-bit count are registered at the output.
//
// Parameters:
//   DATA_W    output word width (2..64)
//   MSB_FIRST 1: first bit lands in deser_data_o[DATA_W-1]; 0: in [0]
//   LEN_W     width of deser_len_o (derived, not overridable)
//
// Ports:
//   clk_i            in   clock, rising edge
//   srst_i           in   synchronous active-high reset
//   data_i           in   serial data bit
//   data_val_i       in   qualifies data_i
//   flush_i          in   emit the pending partial word (flush builds only)
//   deser_data_o     out  assembled word
//   deser_data_val_o out  one-cycle strobe for deser_data_o/deser_len_o
//   deser_len_o      out  number of valid bits in deser_data_o
//
// Build option:
//   DESER_PARAM_FLUSH_EN  defined: partial-word flush is implemented.
//                         undefined: flush_i is ignored and only full words are emitted.

module deser_param #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int LEN_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o,
  output logic [LEN_W-1:0]  deser_len_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DATA_W);

  logic [DATA_W-1:0] sh_q, sh_d, sh_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_last;
  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic [LEN_W-1:0]  emit_len;

`ifdef DESER_PARAM_FLUSH_EN
  logic [LEN_W-1:0]  pend_n;
  logic [LEN_W-1:0]  shamt;
  logic [DATA_W-1:0] sh_cur;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
`endif

  always_comb begin
    sh_shift  = MSB_FIRST ? {sh_q[DATA_W-2:0], data_i} : {data_i, sh_q[DATA_W-1:1]};
    is_last   = data_val_i && (cnt_q == CNT_MAX);
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_data = sh_shift;
    emit_len  = LEN_FULL;
`ifdef DESER_PARAM_FLUSH_EN
    // The bit accepted in the flush cycle is part of the partial word.
    sh_cur = data_val_i ? sh_shift : sh_q;
    pend_n = LEN_W'(cnt_q) + LEN_W'(data_val_i);
    shamt  = LEN_FULL - pend_n;
`endif

    if (data_val_i) begin
      sh_d  = sh_shift;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (is_last) begin
      // A flush arriving with the last bit collapses into this full word.
      emit  = 1'b1;
      cnt_d = '0;
      sh_d  = '0;
    end
`ifdef DESER_PARAM_FLUSH_EN
    else if (flush_i && (pend_n != '0)) begin
      // Received bits sit at the entry end of the register; justify them
      // to the end where the first bit of a full word would be. The
      // register is cleared on every emit, so the vacated bits are zero.
      emit      = 1'b1;
      cnt_d     = '0;
      sh_d      = '0;
      emit_len  = pend_n;
      emit_data = MSB_FIRST ? (sh_cur << shamt) : (sh_cur >> shamt);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sh_q             <= '0;
      cnt_q            <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
      deser_len_o      <= '0;
    end else begin
      sh_q             <= sh_d;
      cnt_q            <= cnt_d;
      deser_data_val_o <= emit;
      if (emit) begin
        deser_data_o <= emit_data;
        deser_len_o  <= emit_len;
      end
    end
  end

endmodule

// File: tb/tb_deser_param.sv
// tb/tb_deser_param.sv - directed self-checking bench for deser_param
//
// Purpose:
//   Drives a DATA_W=16/MSB-first instance and a DATA_W=8/LSB-first instance
//   with directed bit sequences and checks the results against hand-computed words.
//
// Ports: none (top-level bench).
// Build option: DESER_PARAM_FLUSH_EN selects the flush or no-flush expectations.

module tb_deser_param;

  logic        clk = 1'b0;
  logic        srst = 1'b1;

  logic        d16 = 1'b0, v16 = 1'b0, f16 = 1'b0;
  logic [15:0] q16;
  logic        dv16;
  logic [4:0]  len16;

  logic        d8 = 1'b0, v8 = 1'b0, f8 = 1'b0;
  logic [7:0]  q8;
  logic        dv8;
  logic [3:0]  len8;

  int          errors = 0;
  int          checks = 0;
  int          s16 = 0;
  int          s8 = 0;
  int          base16;
  int          base8;
  logic [15:0] w;
  logic [7:0]  w8;

  always #5 clk = ~clk;

  deser_param #(.DATA_W(16), .MSB_FIRST(1'b1)) u_d16 (
    .clk_i(clk), .srst_i(srst), .data_i(d16), .data_val_i(v16), .flush_i(f16),
    .deser_data_o(q16), .deser_data_val_o(dv16), .deser_len_o(len16)
  );

  deser_param #(.DATA_W(8), .MSB_FIRST(1'b0)) u_d8 (
    .clk_i(clk), .srst_i(srst), .data_i(d8), .data_val_i(v8), .flush_i(f8),
    .deser_data_o(q8), .deser_data_val_o(dv8), .deser_len_o(len8)
  );

  // Strobe counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dv16) s16 <= s16 + 1;
    if (dv8)  s8  <= s8 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step16(input logic d, input logic v, input logic f);
    d16 = d; v16 = v; f16 = f;
    d8 = 1'b0; v8 = 1'b0; f8 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic d, input logic v);
    d8 = d; v8 = v; f8 = 1'b0;
    d16 = 1'b0; v16 = 1'b0; f16 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: all outputs zero during and right after reset.
    srst = 1'b1;
    step16(1'b1, 1'b1, 1'b1);
    step16(1'b1, 1'b1, 1'b0);
    check("rst_q16", q16, 16'h0);
    check("rst_dv16", dv16, 1'b0);
    check("rst_len16", len16, 5'd0);
    check("rst_q8", q8, 8'h0);
    check("rst_len8", len8, 4'd0);
    srst = 1'b0;
    step16(1'b0, 1'b0, 1'b0);
    check("post_rst_dv16", dv16, 1'b0);
    check("post_rst_len16", len16, 5'd0);

    // Continuous A5C3, MSB first.
    base16 = s16;
    w = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      step16(w[i], 1'b1, 1'b0);
      if (i == 1) check("a5c3_no_early", dv16, 1'b0);
    end
    check("a5c3_dv", dv16, 1'b1);
    check("a5c3_q", q16, 16'hA5C3);
    check("a5c3_len", len16, 5'd16);
    step16(1'b0, 1'b0, 1'b0);
    check("a5c3_dv_1cyc", dv16, 1'b0);
    check("a5c3_hold_q", q16, 16'hA5C3);
    check("a5c3_count", s16 - base16, 1);

    // Same word with gaps; garbage on data_i while not qualified.
    base16 = s16;
    for (int i = 15; i >= 0; i--) begin
      for (int g = 0; g < (i % 3); g++) step16(~w[i], 1'b0, 1'b0);
      step16(w[i], 1'b1, 1'b0);
    end
    check("gap_q", q16, 16'hA5C3);
    step16(1'b0, 1'b0, 1'b0);
    check("gap_count", s16 - base16, 1);

    // LSB first, DATA_W=8: 1,1,0,0,0,0,0,1 then 5A, back to back.
    base8 = s8;
    w8 = 8'h5A;
    for (int k = 0; k < 16; k++) begin
      logic b;
      if (k < 8) b = (k == 0 || k == 1 || k == 7);
      else       b = w8[k-8];
      step8(b, 1'b1);
      check("lsb_strobe", dv8, (k == 7 || k == 15));
      if (k == 7)  check("lsb_w0", q8, 8'h83);
      if (k == 15) begin
        check("lsb_w1", q8, 8'h5A);
        check("lsb_len", len8, 4'd8);
      end
    end
    step8(1'b0, 1'b0);
    check("lsb_count", s8 - base8, 2);

    // Flush with 5 pending bits 1,0,1,1,0.
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b0);
    step16(1'b0, 1'b0, 1'b1);
`ifdef DESER_PARAM_FLUSH_EN
    check("flush_dv", dv16, 1'b1);
    check("flush_q", q16, 16'hB000);
    check("flush_len", len16, 5'd5);
    w = 16'h1234;
    for (int i = 15; i >= 0; i--) step16(w[i], 1'b1, 1'b0);
    check("after_flush_q", q16, 16'h1234);
    check("after_flush_len", len16, 5'd16);
    // Flush on the same cycle as a bit: 1,1 then 0 with flush -> n=3.
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b1);
    check("flush_same_q", q16, 16'hC000);
    check("flush_same_len", len16, 5'd3);
`else
    check("noflush_dv", dv16, 1'b0);
    // The 5 bits stay pending; 11 more bits complete 1011_0010_0011_0100.
    w = 16'h0234;
    for (int i = 10; i >= 0; i--) step16(w[i], 1'b1, 1'b0);
    check("noflush_q", q16, 16'hB234);
    check("noflush_len", len16, 5'd16);
`endif

    // Flush with nothing pending, then flush on the 16th bit of FFFF.
    step16(1'b0, 1'b0, 1'b0);
    base16 = s16;
    step16(1'b0, 1'b0, 1'b1);
    check("flush_n0_dv", dv16, 1'b0);
    for (int i = 15; i >= 0; i--) step16(1'b1, 1'b1, (i == 0));
    check("ffff_q", q16, 16'hFFFF);
    check("ffff_len", len16, 5'd16);
    step16(1'b0, 1'b0, 1'b0);
    check("ffff_dv_off", dv16, 1'b0);
    check("ffff_count", s16 - base16, 1);

    // Reset after 8 bits of DEAD, then 0F0F.
    w = 16'hDEAD;
    for (int i = 15; i >= 8; i--) step16(w[i], 1'b1, 1'b0);
    srst = 1'b1;
    step16(1'b1, 1'b1, 1'b1);
    check("midrst_q", q16, 16'h0);
    check("midrst_len", len16, 5'd0);
    srst = 1'b0;
    step16(1'b0, 1'b0, 1'b0);
    check("midrst_after_dv", dv16, 1'b0);
    check("midrst_after_q", q16, 16'h0);
    base16 = s16;
    w = 16'h0F0F;
    for (int i = 15; i >= 0; i--) step16(w[i], 1'b1, 1'b0);
    check("midrst_word_q", q16, 16'h0F0F);
    step16(1'b0, 1'b0, 1'b0);
    check("midrst_count", s16 - base16, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deser_param.md
# deser_param

Parametrised serial-to-parallel deserializer, the successor of the fixed 16-bit lab deserializer. It collects a qualified single-bit stream into DATA_W-bit words and supports either bit order. It can optionally emit a partial word on demand (flush) and reports how many bits are valid. It sits behind the serial receive path and feeds word-wide consumers; its ports are registered at the top level as usual.

## Interface
- DATA_W, 16, output word width; legal range 2..64.
- MSB_FIRST, 1, 1: the first received bit lands in deser_data_o[DATA_W-1]; 0: it lands in deser_data_o[0].
- LEN_W, $clog2(DATA_W+1), width of deser_len_o (localparam, not overridable).

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- data_i  in  1  serial data bit, sampled only when data_val_i=1.
- data_val_i  in  1  qualifies data_i for this cycle.
- flush_i  in  1  request to emit the pending partial word (see Configuration).
- deser_data_o  out  DATA_W  assembled word.
- deser_data_val_o  out  1  single-cycle strobe: deser_data_o and deser_len_o are valid.
- deser_len_o  out  LEN_W  number of valid bits in deser_data_o (1..DATA_W).

## Operation
- Internal state is a DATA_W-bit shift register plus a bit counter cnt (0..DATA_W-1).
- Each cycle with data_val_i=1 accepts one bit and increments cnt.
- MSB_FIRST=1: the shift register shifts left and the new bit enters at bit 0.
- MSB_FIRST=0: the shift register shifts right and the new bit enters at bit DATA_W-1.
- Full word: when the accepted bit is the DATA_W-th, the block emits the word with deser_len_o=DATA_W and cnt returns to 0.
- Gaps in data_val_i of any length are allowed. The partial word is held unchanged while data_val_i=0.
- Back-to-back words with data_val_i held high continuously produce one strobe every DATA_W cycles, with no lost bits.
- Partial-word flush (only with the macro): flush_i=1 in a cycle where the pending bit count n is nonzero emits a partial word. n includes the bit accepted in that same cycle. Then cnt returns to 0.
  - MSB_FIRST=1: received bits are left-justified. The first bit is at [DATA_W-1], and bits [DATA_W-n-1:0] are 0.
  - MSB_FIRST=0: the first bit is at [0], and bits [DATA_W-1:n] are 0.
  - deser_len_o = n.
- Flush with n=0 is ignored: no strobe.
- Flush in the same cycle as the DATA_W-th bit produces one full word only.
- deser_data_o and deser_len_o hold the last emitted value between strobes.
- srst_i dominates every other input.
  - Reset values: deser_data_o=0, deser_data_val_o=0, deser_len_o=0, cnt=0, shift register=0.
  - A reset in the middle of a word discards the partial bits; no strobe is produced.

## Timing
- Latency: deser_data_val_o rises on the clock edge that samples the last bit (full word) or the flush request. The output registers are visible the following cycle, one cycle after the input.
- deser_data_val_o is high for exactly one cycle per emitted word.
- There is no backpressure: the consumer must accept every strobe.
- The first bit accepted in the cycle after a strobe or reset belongs to the new word.

## Configuration
- Macro: DESER_PARAM_FLUSH_EN.
- Defined: flush_i behaves as described under Operation, and deser_len_o reports n for partial words or DATA_W for full words.
- Not defined:
  - flush_i is present but ignored.
  - Only full words are emitted, and deser_len_o is constant DATA_W after the first strobe (0 out of reset).
  - The flush logic is not synthesised.

## Test plan
- DATA_W=16, MSB_FIRST=1: send 16'hA5C3 MSB-first with data_val_i held high -> exactly one strobe, one cycle after the 16th bit, with deser_data_o=16'hA5C3 and deser_len_o=16.
- Same word with data_val_i toggling 1,0,0,1,… (random gaps) -> a single strobe with 16'hA5C3; no strobe during the gaps.
- MSB_FIRST=0, DATA_W=8: send bits 1,1,0,0,0,0,0,1 continuously, then 8'h5A LSB-first -> two consecutive strobes 8 cycles apart: 8'h83, then 8'h5A.
- Flush on, DATA_W=16, MSB_FIRST=1: send bits 1,0,1,1,0, then pulse flush_i -> deser_data_o=16'hB000 and deser_len_o=5. A following full word 16'h1234 is then received correctly.
- Flush on: pulse flush_i with n=0 -> no strobe. Pulse flush_i together with the 16th bit of 16'hFFFF -> one strobe only, with deser_len_o=16.
- Reset after 8 bits of 16'hDEAD, then send 16'h0F0F -> a single strobe with 16'h0F0F. All outputs read 0 during and immediately after reset.
